// File: rtl/tick_receiver.sv
// ============================================================================
// tick_receiver
// ----------------------------------------------------------------------------
// Receiving end of the slow divided-clock toggle produced by the one-second
// divider. The asynchronous toggle is synchronised into the clk domain and
// each toggle edge (rising or falling) becomes one registered tick. The tick
// drives a note-scroll position counter under a small run-control FSM
// (IDLE / RUN / DONE). The block sits between the divider and the note/display
// logic.
//
// Optional feature (compile-time macro): TICK_WATCHDOG_EN
//   When defined, a 32-bit watchdog counts clk cycles spent in RUN without a
//   tick and raises a sticky stall flag after TIMEOUT cycles. The TIMEOUT
//   parameter only exists in that build. When undefined, no counter is built
//   and stall is a constant 0.
//
// Parameters
//   POS_W    width of pos
//   POS_MAX  last position value (must be <= 2**POS_W-1)
//   WRAP     1: pos wraps POS_MAX->0 and stays in RUN
//            0: pos saturates at POS_MAX and the FSM moves to DONE
//   TIMEOUT  cycles without a tick before stall (watchdog build only)
//
// Ports
//   clk         in   1      system clock
//   rst         in   1      reset, asynchronous, active-high
//   tick_in     in   1      toggle from divider, async to clk
//   start       in   1      IDLE->RUN request
//   stop        in   1      RUN/DONE->IDLE request, pos held
//   clear       in   1      pos<-0, FSM->IDLE
//   tick_pulse  out  1      one-cycle pulse per synchronised tick_in edge
//   pos         out  POS_W  current position
//   wrap        out  1      one-cycle pulse on POS_MAX->0 (WRAP=1 only)
//   running     out  1      high while the FSM is in RUN
//   done        out  1      high while the FSM is in DONE (WRAP=0 only)
//   stall       out  1      watchdog flag, 0 when the watchdog is not built
//   dbg_state   out  2      current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Control interface: start/stop/clear are plain level-sampled requests with
// no handshake. Whatever is high at a rising clk edge is acted on in that
// cycle, with priority clear > stop > start > tick; the lower-priority
// events of that cycle are dropped.
// ============================================================================
module tick_receiver #(
    parameter int POS_W   = 7,
    parameter int POS_MAX = 127,
    parameter int WRAP    = 1
`ifdef TICK_WATCHDOG_EN
    ,
    parameter int unsigned TIMEOUT = 60000000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    output logic             tick_pulse,
    output logic [POS_W-1:0] pos,
    output logic             wrap,
    output logic             running,
    output logic             done,
    output logic             stall,
    output logic [1:0]       dbg_state
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [POS_W-1:0] POS_MAX_V  = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);
    localparam logic [POS_W-1:0] POS_MAX_M1 = POS_MAX_V - POS_ONE;

    // ------------------------------------------------------------------------
    // Synchroniser and edge detect
    // r_s1/r_s2 form the metastability chain; r_s3 holds the previous
    // synchronised level so s2^s3 flags any change of tick_in.
    // ------------------------------------------------------------------------
    logic       r_s1;
    logic       r_s2;
    logic       r_s3;
    logic [1:0] r_arm_cnt;
    logic       w_armed;
    logic       w_tick;
    logic       r_tick_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= tick_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // The sync chain resets to 0, so if tick_in is already high at reset
    // release the chain fills with 1s and s2^s3 would report a fake edge.
    // Edges are ignored until three clk edges after release, by which time
    // the chain reflects the real input level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arm_cnt <= 2'd0;
        end else if (!w_armed) begin
            r_arm_cnt <= r_arm_cnt + 2'd1;
        end
    end

    assign w_armed = (r_arm_cnt == 2'd3);
    assign w_tick  = (r_s2 ^ r_s3) & w_armed;

    // tick_pulse is independent of the FSM: every armed edge shows up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_pulse <= 1'b0;
        end else begin
            r_tick_pulse <= w_tick;
        end
    end

    // ------------------------------------------------------------------------
    // Run-control FSM and position counter
    // pos updates on the same edge that raises tick_pulse, so the new pos
    // value and the pulse appear together.
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] w_pos_nxt;
    logic             w_wrap_nxt;
    logic             r_wrap;
    logic             r_running;
    logic             r_done;

    always_comb begin
        // Illegal encodings fall back to IDLE.
        w_state_nxt = ((r_state == ST_RUN) || (r_state == ST_DONE)) ? r_state : ST_IDLE;
        w_pos_nxt   = r_pos;
        w_wrap_nxt  = 1'b0;

        if (clear) begin
            w_state_nxt = ST_IDLE;
            w_pos_nxt   = '0;
        end else if (stop) begin
            w_state_nxt = ST_IDLE;
        end else if (start && (r_state == ST_IDLE)) begin
            // A tick arriving in the same cycle is consumed by the start.
            w_state_nxt = ST_RUN;
        end else if (w_tick && (r_state == ST_RUN)) begin
            if (WRAP != 0) begin
                if (r_pos >= POS_MAX_V) begin
                    w_pos_nxt  = '0;
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_pos_nxt = r_pos + POS_ONE;
                end
            end else begin
                // >= also covers re-entering RUN from DONE with pos at
                // POS_MAX: the next tick keeps pos saturated and returns
                // to DONE instead of overflowing.
                if (r_pos >= POS_MAX_M1) begin
                    w_pos_nxt   = POS_MAX_V;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_pos_nxt = r_pos + POS_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pos     <= '0;
            r_wrap    <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pos     <= w_pos_nxt;
            r_wrap    <= w_wrap_nxt;
            // Decoded from the next state so the flags line up with r_state.
            r_running <= (w_state_nxt == ST_RUN);
            r_done    <= (w_state_nxt == ST_DONE);
        end
    end

    // ------------------------------------------------------------------------
    // Optional watchdog
    // ------------------------------------------------------------------------
`ifdef TICK_WATCHDOG_EN
    localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT);

    logic [31:0] r_wd_cnt;
    logic        r_stall;
    logic        w_wd_clr;
    logic        w_wd_inc;

    // Any activity, or simply not running, restarts the count.
    assign w_wd_clr = w_tick | start | stop | clear | (r_state != ST_RUN);
    assign w_wd_inc = !w_wd_clr && (r_wd_cnt != WD_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt <= '0;
        end else if (w_wd_clr) begin
            r_wd_cnt <= '0;
        end else if (w_wd_inc) begin
            r_wd_cnt <= r_wd_cnt + 32'd1;
        end
    end

    // stall rises on the edge where the count reaches WD_LIMIT and stays up
    // (the count parks at WD_LIMIT) until a tick, stop or clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= 1'b0;
        end else if (w_tick || stop || clear) begin
            r_stall <= 1'b0;
        end else if (w_wd_inc && (r_wd_cnt == (WD_LIMIT - 32'd1))) begin
            r_stall <= 1'b1;
        end
    end

    assign stall = r_stall;
`else
    assign stall = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign tick_pulse = r_tick_pulse;
    assign pos        = r_pos;
    assign wrap       = r_wrap;
    assign running    = r_running;
    assign done       = r_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_tick_receiver.sv
// ============================================================================
// tb_tick_receiver
// Directed bench for tick_receiver. Three instances share one stimulus:
//   dut_m : default parameters (POS_MAX=127, WRAP=1)
//   dut_w : POS_MAX=3, WRAP=1  (wrap behaviour)
//   dut_s : POS_MAX=3, WRAP=0  (saturate / DONE behaviour)
// With TICK_WATCHDOG_EN defined a fourth instance (TIMEOUT=100) is added.
// Inputs change 1 time unit after a rising clk edge; outputs are read on the
// falling edge or 1 unit after a rising edge.
// ============================================================================
module tb_tick_receiver;

    localparam int ST_IDLE = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_DONE = 2;

    logic clk = 1'b0;
    logic rst;
    logic tick_in;
    logic start;
    logic stop;
    logic clear;

    logic       tp_m, wr_m, run_m, done_m, stall_m;
    logic [6:0] pos_m;
    logic [1:0] st_m;
    logic       tp_w, wr_w, run_w, done_w, stall_w;
    logic [6:0] pos_w;
    logic [1:0] st_w;
    logic       tp_s, wr_s, run_s, done_s, stall_s;
    logic [6:0] pos_s;
    logic [1:0] st_s;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int wrap_cnt = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    tick_receiver dut_m (
        .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop), .clear(clear),
        .tick_pulse(tp_m), .pos(pos_m), .wrap(wr_m), .running(run_m), .done(done_m),
        .stall(stall_m), .dbg_state(st_m)
    );

    tick_receiver #(.POS_W(7), .POS_MAX(3), .WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop), .clear(clear),
        .tick_pulse(tp_w), .pos(pos_w), .wrap(wr_w), .running(run_w), .done(done_w),
        .stall(stall_w), .dbg_state(st_w)
    );

    tick_receiver #(.POS_W(7), .POS_MAX(3), .WRAP(0)) dut_s (
        .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop), .clear(clear),
        .tick_pulse(tp_s), .pos(pos_s), .wrap(wr_s), .running(run_s), .done(done_s),
        .stall(stall_s), .dbg_state(st_s)
    );

`ifdef TICK_WATCHDOG_EN
    logic       tp_d, wr_d, run_d, done_d, stall_d;
    logic [6:0] pos_d;
    logic [1:0] st_d;

    tick_receiver #(.POS_W(7), .POS_MAX(127), .WRAP(1), .TIMEOUT(100)) dut_d (
        .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop), .clear(clear),
        .tick_pulse(tp_d), .pos(pos_d), .wrap(wr_d), .running(run_d), .done(done_d),
        .stall(stall_d), .dbg_state(st_d)
    );
`endif

    // Pulse monitors: one count per high cycle, so a stretched pulse shows
    // up as an extra count.
    always @(negedge clk) begin
        if (tp_m) pulse_cnt++;
        if (wr_w) wrap_cnt++;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    // Toggle tick_in and wait (bounded) for tick_pulse on dut_m. lat is the
    // number of rising edges until the pulse is seen; returns 1 unit after
    // the edge that ends a one-cycle pulse.
    task automatic do_tick(output int lat);
        lat = 0;
        tick_in = ~tick_in;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!tp_m && lat < 8);
        @(posedge clk); #1;
    endtask

    // Toggle tick_in and raise the given controls for exactly the cycle in
    // which the synchronised edge is registered.
    task automatic tick_with(input logic c_clear, input logic c_stop, input logic c_start);
        tick_in = ~tick_in;
        @(posedge clk);
        @(posedge clk); #1;
        clear = c_clear;
        stop  = c_stop;
        start = c_start;
        @(posedge clk); #1;
        clear = 1'b0;
        stop  = 1'b0;
        start = 1'b0;
    endtask

    // ---------------- bench timeout ----------------
    initial begin
        #200000;
        $display("FAIL bench_timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "bench timeout");
    end

    // ---------------- stimulus ----------------
    int lat;
    int base;
    int exp_w  [5] = '{1, 2, 3, 0, 1};
    int exp_wc [5] = '{0, 0, 0, 1, 1};
    int exp_s  [5] = '{1, 2, 3, 3, 3};
    int exp_d  [5] = '{0, 0, 1, 1, 1};

    initial begin
        // T1: reset with tick_in high, no spurious tick after release
        rst = 1'b1; tick_in = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
        idle(3);
        check("rst_pulse", tp_m, 0);
        check("rst_pos", pos_m, 0);
        check("rst_running", run_m, 0);
        rst = 1'b0;
        idle(12);
        check("t1_no_pulse", pulse_cnt, 0);
        check("t1_pos", pos_m, 0);
        check("t1_state", st_m, ST_IDLE);
        check("t1_done", done_s, 0);
        check("t1_wrap", wrap_cnt, 0);
        check("t1_stall", stall_m, 0);

        // T2/T3/T4: start then five ticks spaced ~20 clk
        pulse_start();
        check("t2_running", run_m, 1);
        check("t2_state", st_m, ST_RUN);
        idle(5);
        for (int k = 0; k < 5; k++) begin
            do_tick(lat);
            check("t2_latency", (lat >= 3 && lat <= 4), 1);
            check("t2_width", tp_m, 0);
            check("t2_pos", pos_m, k + 1);
            check("t3_pos", pos_w, exp_w[k]);
            check("t3_wrap_cnt", wrap_cnt, exp_wc[k]);
            check("t4_pos", pos_s, exp_s[k]);
            check("t4_done", done_s, exp_d[k]);
            check("t4_running", run_s, 1 - exp_d[k]);
            idle(15);
        end
        check("t2_pulse_cnt", pulse_cnt, 5);
        check("t4_state", st_s, ST_DONE);

        // T4 tail: clear returns everything to IDLE with pos 0
        pulse_clear();
        check("t4_clr_pos", pos_s, 0);
        check("t4_clr_done", done_s, 0);
        check("t4_clr_state", st_s, ST_IDLE);
        check("t4_clr_pos_m", pos_m, 0);

        // Run to pos 7 on dut_m
        pulse_start();
        for (int k = 0; k < 7; k++) begin
            do_tick(lat);
            idle(15);
        end
        check("run7_pos", pos_m, 7);
        check("run7_pos_w", pos_w, 3);
        check("run7_wrap_cnt", wrap_cnt, 2);
        check("run7_pos_s", pos_s, 3);
        check("run7_done_s", done_s, 1);

        // start ignored in DONE and in RUN
        pulse_start();
        check("done_start_ign", st_s, ST_DONE);
        check("run_start_ign", pos_m, 7);
        check("run_start_state", st_m, ST_RUN);

        // T5a: clear + stop + tick in one cycle
        tick_with(1'b1, 1'b1, 1'b0);
        check("t5_tick_seen", tp_m, 1);
        check("t5_pos", pos_m, 0);
        check("t5_state", st_m, ST_IDLE);
        check("t5_running", run_m, 0);
        check("t5_done_s", done_s, 0);
        idle(15);

        // T5b: start + tick in IDLE in one cycle
        base = pulse_cnt;
        tick_with(1'b0, 1'b0, 1'b1);
        check("t5b_tick_seen", tp_m, 1);
        check("t5b_running", run_m, 1);
        check("t5b_pos", pos_m, 0);
        idle(15);

        // Two ticks, then stop holds pos; tick in IDLE is ignored
        do_tick(lat); idle(15);
        do_tick(lat); idle(15);
        check("g_pos", pos_m, 2);
        pulse_stop();
        check("stop_pos", pos_m, 2);
        check("stop_state", st_m, ST_IDLE);
        check("stop_running", run_m, 0);
        do_tick(lat);
        check("idle_tick_pulse", pulse_cnt - base, 4);
        check("idle_tick_pos", pos_m, 2);
        idle(15);

        // stop from DONE holds pos at POS_MAX
        pulse_start();
        do_tick(lat); idle(15);
        check("h_pos_m", pos_m, 3);
        check("h_done_s", done_s, 1);
        pulse_stop();
        check("h_stop_pos_s", pos_s, 3);
        check("h_stop_done_s", done_s, 0);
        check("h_stop_state_s", st_s, ST_IDLE);

        // Mid-operation reset with tick_in high: back to reset values and
        // the arm period applies again
        pulse_start();
        rst = 1'b1;
        #2;
        check("mid_rst_pos", pos_m, 0);
        check("mid_rst_running", run_m, 0);
        check("mid_rst_state", st_m, ST_IDLE);
        idle(2);
        base = pulse_cnt;
        rst = 1'b0;
        idle(12);
        check("mid_rst_no_pulse", pulse_cnt - base, 0);
        check("mid_rst_pos_after", pos_m, 0);
        check("stall_default", stall_m, 0);

`ifdef TICK_WATCHDOG_EN
        // T6: watchdog with TIMEOUT=100
        pulse_start();
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!stall_d && lat < 150);
        check("t6_stall_cycle", lat, 100);
        idle(10);
        check("t6_stall_sticky", stall_d, 1);
        do_tick(lat);
        check("t6_stall_clr", stall_d, 0);
        check("t6_pos", pos_d, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
